// File: rtl/sdram_bram_resp.sv
// sdram_bram_resp: on-chip BRAM target speaking the sdram_top user protocol.
// It replaces the SDRAM controller on boards without SDRAM and gives the bus bridge a target
// with fixed, programmable timing: init delay, read latency and write latency.
// Optional refresh stalls are compiled in when SDRAM_EMU_REFRESH_EN is defined.
module sdram_bram_resp #(
  parameter int unsigned AW          = 12,
  parameter int unsigned INIT_CYCLES = 200,
  parameter int unsigned RD_LAT      = 4,
  parameter int unsigned WR_LAT      = 2,
  parameter int unsigned REF_PERIOD  = 780,
  parameter int unsigned REF_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [1:0]  sdram_byteenable,
  input  logic [21:0] sys_wraddr,
  input  logic [21:0] sys_rdaddr,
  input  logic [15:0] sys_data_in,
  output logic [15:0] sys_data_out,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic        sdram_init_done
);

  localparam int unsigned CW = 16;

  localparam logic [2:0] StInit    = 3'd0;
  localparam logic [2:0] StIdle    = 3'd1;
  localparam logic [2:0] StRdWait  = 3'd2;
  localparam logic [2:0] StWrWait  = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
`ifdef SDRAM_EMU_REFRESH_EN
  localparam logic [2:0] StRefresh = 3'd5;
`endif

  logic [2:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] wr_addr_q;
  logic [15:0]   wr_data_q;
  logic [1:0]    be_q;
  logic [15:0]   rd_data_q;
  logic [15:0]   data_out_q;
  logic          wr_ack_q;
  logic          rd_ack_q;
  logic          init_done_q;
  logic          done_wr_q;  // DONE was entered from a write, so wait on wr_req
  logic          mem_we;
  logic          mem_re;

  logic [15:0] mem [2**AW];

  // Upper address bits alias away.
  logic unused_addr;
  assign unused_addr = ^{sys_wraddr[21:AW], sys_rdaddr[21:AW]};

`ifdef SDRAM_EMU_REFRESH_EN
  logic [CW-1:0] ref_cnt_q;
  logic          ref_pending;
  logic          ref_taken;

  assign ref_pending = (ref_cnt_q == CW'(REF_PERIOD));
  assign ref_taken   = (state_q == StIdle) && ref_pending;

  // Refresh interval counter: runs once init is done, parks at the period until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q <= '0;
    end else if (!init_done_q || ref_taken) begin
      ref_cnt_q <= '0;
    end else if (!ref_pending) begin
      ref_cnt_q <= ref_cnt_q + CW'(1);
    end
  end
`endif

  // BRAM strobes: read one clock ahead of the ack, write on the ack clock.
  always_comb begin
    mem_we = (state_q == StWrWait) && (cnt_q == CW'(WR_LAT)) && sdram_wr_req;
    mem_re = (state_q == StRdWait) && (cnt_q == CW'(RD_LAT - 1));
  end

  // BRAM array with byte-lane writes and a registered read port; never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (be_q[0]) mem[wr_addr_q][7:0]  <= wr_data_q[7:0];
      if (be_q[1]) mem[wr_addr_q][15:8] <= wr_data_q[15:8];
    end
    if (mem_re) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  // Control FSM: init delay, request arbitration, fixed latency, one ack per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      be_q        <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      init_done_q <= 1'b0;
      done_wr_q   <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        StInit: begin
          if (cnt_q == CW'(INIT_CYCLES - 1)) begin
            init_done_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StIdle: begin
`ifdef SDRAM_EMU_REFRESH_EN
          if (ref_pending) begin
            cnt_q   <= CW'(1);
            state_q <= StRefresh;
          end else
`endif
          if (sdram_wr_req) begin
            wr_addr_q <= sys_wraddr[AW-1:0];
            wr_data_q <= sys_data_in;
            be_q      <= sdram_byteenable;
            cnt_q     <= CW'(1);
            state_q   <= StWrWait;
          end else if (sdram_rd_req) begin
            rd_addr_q <= sys_rdaddr[AW-1:0];
            cnt_q     <= CW'(1);
            state_q   <= StRdWait;
          end
        end
        StWrWait: begin
          if (!sdram_wr_req) begin
            state_q <= StIdle;
          end else if (cnt_q == CW'(WR_LAT)) begin
            wr_ack_q  <= 1'b1;
            done_wr_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StRdWait: begin
          if (!sdram_rd_req) begin
            state_q <= StIdle;
          end else if (cnt_q == CW'(RD_LAT)) begin
            rd_ack_q   <= 1'b1;
            data_out_q <= rd_data_q;
            done_wr_q  <= 1'b0;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          // Only the acked request must drop; a pending request of the other type
          // (write won a tie) is served from IDLE next.
          if (done_wr_q ? !sdram_wr_req : !sdram_rd_req) begin
            state_q <= StIdle;
          end
        end
`ifdef SDRAM_EMU_REFRESH_EN
        StRefresh: begin
          if (cnt_q == CW'(REF_CYCLES)) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        default: begin
          state_q <= StInit;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sys_data_out    = data_out_q;
  assign sdram_wr_ack    = wr_ack_q;
  assign sdram_rd_ack    = rd_ack_q;
  assign sdram_init_done = init_done_q;

endmodule

// File: tb/tb_sdram_bram_resp.sv
// Self-checking bench for sdram_bram_resp (default build, refresh stalls disabled).
module tb_sdram_bram_resp;
  localparam int AW          = 12;
  localparam int INIT_CYCLES = 200;
  localparam int RD_LAT      = 4;
  localparam int WR_LAT      = 2;

  logic        clk;
  logic        rst_n;
  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic [1:0]  sdram_byteenable;
  logic [21:0] sys_wraddr;
  logic [21:0] sys_rdaddr;
  logic [15:0] sys_data_in;
  logic [15:0] sys_data_out;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic        sdram_init_done;

  int total = 0;
  int bad   = 0;

  logic [15:0] model [int];  // expected memory, keyed by aliased word address
  logic [15:0] last_rd;      // value sys_data_out should be holding

  sdram_bram_resp #(
    .AW          (AW),
    .INIT_CYCLES (INIT_CYCLES),
    .RD_LAT      (RD_LAT),
    .WR_LAT      (WR_LAT),
    .REF_PERIOD  (780),
    .REF_CYCLES  (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sdram_wr_req     (sdram_wr_req),
    .sdram_rd_req     (sdram_rd_req),
    .sdram_byteenable (sdram_byteenable),
    .sys_wraddr       (sys_wraddr),
    .sys_rdaddr       (sys_rdaddr),
    .sys_data_in      (sys_data_in),
    .sys_data_out     (sys_data_out),
    .sdram_wr_ack     (sdram_wr_ack),
    .sdram_rd_ack     (sdram_rd_ack),
    .sdram_init_done  (sdram_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int alias_of(input logic [21:0] a);
    return int'(a) % (1 << AW);
  endfunction

  // Called right after rst_n is released on a falling edge; optionally pokes rd_req early.
  task automatic wait_init(input bit poke);
    int n = 0;
    int acks = 0;
    if (poke) sdram_rd_req = 1'b1;
    while (!sdram_init_done && n < INIT_CYCLES + 50) begin
      @(negedge clk);
      n++;
      if (sdram_wr_ack || sdram_rd_ack) acks++;
      if (n == INIT_CYCLES - 10) sdram_rd_req = 1'b0;
    end
    chk("init_lat", n, INIT_CYCLES);
    chk("init_no_ack", acks, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic write_txn(input logic [21:0] a, input logic [15:0] d, input logic [1:0] be,
                           input int hold);
    int n = 0;
    int extra = 0;
    bit got = 1'b0;
    logic [15:0] v;
    sys_wraddr = a; sys_data_in = d; sdram_byteenable = be; sdram_wr_req = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (sdram_rd_ack) extra++;
      if (sdram_wr_ack) got = 1'b1;
    end
    chk("wr_ack_seen", got, 1);
    chk("wr_lat", n, WR_LAT + 1);
    repeat (hold) begin
      @(negedge clk);
      if (sdram_wr_ack || sdram_rd_ack) extra++;
    end
    sdram_wr_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (sdram_wr_ack || sdram_rd_ack) extra++;
    end
    chk("wr_single", extra, 0);
    v = model.exists(alias_of(a)) ? model[alias_of(a)] : 16'h0000;
    if (be[0]) v[7:0]  = d[7:0];
    if (be[1]) v[15:8] = d[15:8];
    model[alias_of(a)] = v;
  endtask

  task automatic read_txn(input logic [21:0] a, input int hold);
    int n = 0;
    int extra = 0;
    bit got = 1'b0;
    sys_rdaddr = a; sdram_rd_req = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (sdram_wr_ack) extra++;
      if (sdram_rd_ack) got = 1'b1;
    end
    chk("rd_ack_seen", got, 1);
    chk("rd_lat", n, RD_LAT + 1);
    if (model.exists(alias_of(a))) begin
      chk("rd_data", sys_data_out, model[alias_of(a)]);
      last_rd = model[alias_of(a)];
    end
    repeat (hold) begin
      @(negedge clk);
      if (sdram_wr_ack || sdram_rd_ack) extra++;
    end
    sdram_rd_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (sdram_wr_ack || sdram_rd_ack) extra++;
    end
    chk("rd_single", extra, 0);
  endtask

  initial begin
    int n;
    int acks;
    logic [21:0] a;
    rst_n = 1'b0; sdram_wr_req = 1'b0; sdram_rd_req = 1'b0; sdram_byteenable = 2'b00;
    sys_wraddr = '0; sys_rdaddr = '0; sys_data_in = '0; last_rd = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_init_done", sdram_init_done, 0);
    chk("rst_wr_ack", sdram_wr_ack, 0);
    chk("rst_rd_ack", sdram_rd_ack, 0);
    chk("rst_data_out", sys_data_out, 16'h0000);
    rst_n = 1'b1;
    wait_init(1'b1);

    // Basic write/read with long request hold.
    write_txn(22'd5, 16'hA55A, 2'b11, 3);
    read_txn(22'd5, 3);

    // Byte enables.
    write_txn(22'd7, 16'hFFFF, 2'b11, 1);
    write_txn(22'd7, 16'h1234, 2'b01, 1);
    read_txn(22'd7, 0);
    chk("be01_data", sys_data_out, 16'hFF34);
    write_txn(22'd7, 16'h0000, 2'b00, 0);
    read_txn(22'd7, 0);
    chk("be00_data", sys_data_out, 16'hFF34);

    // Simultaneous requests; write goes to an aliased address, read the base address.
    sys_wraddr = 22'((1 << AW) + 3); sys_data_in = 16'hBEEF; sdram_byteenable = 2'b11;
    sys_rdaddr = 22'd3;
    sdram_wr_req = 1'b1; sdram_rd_req = 1'b1;
    n = 0; acks = 0;
    while (!sdram_wr_ack && n < 100) begin
      @(negedge clk);
      n++;
      if (sdram_rd_ack) acks++;
    end
    chk("both_wr_lat", n, WR_LAT + 1);
    chk("both_no_early_rd", acks, 0);
    model[3] = 16'hBEEF;
    @(negedge clk);
    sdram_wr_req = 1'b0;
    n = 0;
    while (!sdram_rd_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    // One clock to leave DONE, one to accept, then the read latency.
    chk("both_rd_lat", n, RD_LAT + 2);
    chk("alias_data", sys_data_out, 16'hBEEF);
    last_rd = 16'hBEEF;
    @(negedge clk);
    sdram_rd_req = 1'b0;
    repeat (2) @(negedge clk);

    // Read abort right after accept.
    read_txn(22'd5, 0);
    sys_rdaddr = 22'd7; sdram_rd_req = 1'b1;
    @(negedge clk);
    sdram_rd_req = 1'b0;
    acks = 0;
    repeat (RD_LAT + 3) begin
      @(negedge clk);
      if (sdram_rd_ack || sdram_wr_ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_data_hold", sys_data_out, last_rd);

    // Reset inside WR_WAIT.
    write_txn(22'd9, 16'h1111, 2'b11, 0);
    sys_wraddr = 22'd9; sys_data_in = 16'h2222; sdram_byteenable = 2'b11; sdram_wr_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; sdram_wr_req = 1'b0;
    #1;
    chk("rstmid_wr_ack", sdram_wr_ack, 0);
    chk("rstmid_init_done", sdram_init_done, 0);
    chk("rstmid_data_out", sys_data_out, 16'h0000);
    last_rd = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(1'b0);
    read_txn(22'd9, 1);

    // Randomized traffic over 16 locations with random aliasing upper bits.
    for (int i = 0; i < 16; i++) begin
      a = (22'($urandom) << AW) | 22'(i);
      write_txn(a, 16'($urandom), 2'b11, $urandom_range(0, 2));
    end
    for (int i = 0; i < 40; i++) begin
      a = (22'($urandom) << AW) | 22'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        write_txn(a, 16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
      end else begin
        read_txn(a, $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
